// File: rtl/pe_array_pkg.sv
// Shared types and constants for the PE array sequencer.
package pe_array_pkg;

  localparam int unsigned DEF_ROWS   = 9;
  localparam int unsigned DEF_COLS   = 8;
  localparam int unsigned DEF_PE_LAT = 1;
  localparam int unsigned DEF_VEC_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } pe_state_e;

  // Last STREAM step: final vector reaches row ROWS-1, then drains through every column.
  function automatic int unsigned t_end(input int unsigned nv, input int unsigned rows,
                                        input int unsigned cols, input int unsigned pe_lat);
    return nv - 1 + cols - 1 + rows * pe_lat;
  endfunction

endpackage

// File: rtl/pe_skew_mask.sv
// Window compare: bit i is set when (t - BASE - i) lies in [0, nv).
module pe_skew_mask #(
  parameter int unsigned N    = 9,
  parameter int unsigned BASE = 0,
  parameter int unsigned TW   = 24,
  parameter int unsigned VW   = 16
) (
  input  logic          en,
  input  logic [TW-1:0] t,
  input  logic [VW-1:0] nv,
  output logic [N-1:0]  mask_c
);

  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      // Lower bound checked first so the subtraction never underflows.
      if (en && (t >= TW'(BASE + i)) && ((t - TW'(BASE + i)) < TW'(nv)))
        mask_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the weight-stationary PE array: weight load, skewed ifmap
// streaming, and row/column validity masks.
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned PE_LAT = DEF_PE_LAT,
  parameter int unsigned VEC_W  = DEF_VEC_W
) (
  input  logic                     iClk,
  input  logic                     iRest_n,
  input  logic                     start,
  input  logic                     keep_w,
  input  logic [VEC_W-1:0]         num_vec,
  input  logic                     abort,
  output logic                     enable_w,
  output logic                     Run,
  output logic [$clog2(ROWS)-1:0]  w_rd_addr,
  output logic [VEC_W-1:0]         vec_idx,
  output logic [ROWS-1:0]          row_valid,
  output logic [COLS-1:0]          col_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned TW = VEC_W + 8;
  localparam int unsigned AW = $clog2(ROWS);

  pe_state_e         state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [VEC_W-1:0]  nv_q, nv_d;
  logic [TW-1:0]     t_end_w;

  logic              enable_w_q, enable_w_d;
  logic              run_q, run_d;
  logic [AW-1:0]     w_rd_addr_q, w_rd_addr_d;
  logic [VEC_W-1:0]  vec_idx_q, vec_idx_d;
  logic [ROWS-1:0]   row_valid_q, row_valid_d;
  logic [COLS-1:0]   col_valid_q, col_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stream_d;

  assign t_end_w = TW'(t_end(32'(nv_q), ROWS, COLS, PE_LAT));

  // Next state, counter (k in LOAD_W, t in STREAM) and the values the output flops take.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          nv_d  = num_vec;
          cnt_d = '0;
          if (keep_w) state_d = (num_vec == '0) ? DONE : STREAM;
          else        state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        if (cnt_q == TW'(ROWS - 1)) begin
          cnt_d   = '0;
          state_d = (nv_q == '0) ? DONE : STREAM;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      STREAM: begin
        if (cnt_q == t_end_w) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    stream_d    = (state_d == STREAM);
    enable_w_d  = (state_d == LOAD_W);
    run_d       = stream_d;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    w_rd_addr_d = '0;
    vec_idx_d   = '0;
    if (state_d == LOAD_W) w_rd_addr_d = AW'(ROWS - 1) - AW'(cnt_d);
    if (stream_d) vec_idx_d = (cnt_d < TW'(nv_d)) ? VEC_W'(cnt_d) : (nv_d - VEC_W'(1));
  end

  pe_skew_mask #(.N(ROWS), .BASE(0), .TW(TW), .VW(VEC_W)) u_row_mask (
    .en     (stream_d),
    .t      (cnt_d),
    .nv     (nv_d),
    .mask_c (row_valid_d)
  );

  pe_skew_mask #(.N(COLS), .BASE(ROWS * PE_LAT), .TW(TW), .VW(VEC_W)) u_col_mask (
    .en     (stream_d),
    .t      (cnt_d),
    .nv     (nv_d),
    .mask_c (col_valid_d)
  );

  always_ff @(posedge iClk) begin
    if (!iRest_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nv_q        <= '0;
      enable_w_q  <= 1'b0;
      run_q       <= 1'b0;
      w_rd_addr_q <= '0;
      vec_idx_q   <= '0;
      row_valid_q <= '0;
      col_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nv_q        <= nv_d;
      enable_w_q  <= enable_w_d;
      run_q       <= run_d;
      w_rd_addr_q <= w_rd_addr_d;
      vec_idx_q   <= vec_idx_d;
      row_valid_q <= row_valid_d;
      col_valid_q <= col_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign enable_w  = enable_w_q;
  assign Run       = run_q;
  assign w_rd_addr = w_rd_addr_q;
  assign vec_idx   = vec_idx_q;
  assign row_valid = row_valid_q;
  assign col_valid = col_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
